// File: rtl/daa_pkg.sv
// ============================================================================
// Module  : daa_pkg
// Brief   : Shared constants, field widths and FSM encoding for the DAA reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package daa_pkg;

   localparam logic [1:0] SEL_RES_LO   = 2'd0;
   localparam logic [1:0] SEL_ERES_EXP = 2'd1;
   localparam logic [1:0] SEL_ERES_MID = 2'd2;
   localparam logic [1:0] SEL_RES_HI   = 2'd3;

   localparam int RES_W  = 10;
   localparam int ERES_W = 18;
   localparam int EXP_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE_W = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_PRESENT  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/daa_result_reader_if.sv
// ============================================================================
// Module  : daa_result_reader_if
// Brief   : MAC byte bus plus the valid/ready result word of the DAA reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface daa_result_reader_if;
   import daa_pkg::*;

   logic [1:0]        sel_o;
   logic [7:0]        byte_i;
   logic              hold_o;
   logic [RES_W-1:0]  res_o;
   logic [15:0]       res_sext_o;
   logic [ERES_W-1:0] eres_o;
   logic [EXP_W-1:0]  exp_o;
   logic              fmt_err_o;
   logic              valid_o;
   logic              ready_i;

   modport master (
      output sel_o, hold_o, res_o, res_sext_o, eres_o, exp_o, fmt_err_o, valid_o,
      input  byte_i, ready_i
   );

   modport slave (
      input  sel_o, hold_o, res_o, res_sext_o, eres_o, exp_o, fmt_err_o, valid_o,
      output byte_i, ready_i
   );

endinterface

`default_nettype wire

// File: rtl/daa_byte_unpack.sv
// ============================================================================
// Module  : daa_byte_unpack
// Brief   : Rebuilds result/eResult/expResult from the four multiplexed bytes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module daa_byte_unpack
   import daa_pkg::*;
(
   input  wire logic [7:0]        i_byte0,
   input  wire logic [7:0]        i_byte1,
   input  wire logic [7:0]        i_byte2,
   input  wire logic [7:0]        i_byte3,
   output logic      [RES_W-1:0]  o_res,
   output logic      [ERES_W-1:0] o_eres,
   output logic      [EXP_W-1:0]  o_exp,
   output logic                   o_fmt_err
);

   // eResult is split low-to-high across bytes 1, 2 and 3.
   assign o_res     = {i_byte3[6:5], i_byte0};
   assign o_eres    = {i_byte3[4:0], i_byte2, i_byte1[7:3]};
   assign o_exp     = i_byte1[2:0];
   assign o_fmt_err = i_byte3[7];

endmodule

`default_nettype wire

// File: rtl/daa_result_reader.sv
// ============================================================================
// Module  : daa_result_reader
// Brief   : Steps the MAC byte select, captures four bytes under hold, presents the word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module daa_result_reader
   import daa_pkg::*;
#(
   parameter int SETTLE   = 1,
   parameter bit SIGN_EXT = 1'b1
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              start_i,
   output logic                   busy_o,
   daa_result_reader_if.master    bus
);

   localparam logic [3:0] c_CNT_RELOAD = 4'(SETTLE - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [1:0]        r_idx;
   logic [1:0]        r_sel;
   logic              r_hold;
   logic [7:0]        r_slot0;
   logic [7:0]        r_slot1;
   logic [7:0]        r_slot2;
   logic [RES_W-1:0]  r_res;
   logic [15:0]       r_res_sext;
   logic [ERES_W-1:0] r_eres;
   logic [EXP_W-1:0]  r_exp;
   logic              r_fmt_err;
   logic              r_valid;

   logic [RES_W-1:0]  w_res;
   logic [ERES_W-1:0] w_eres;
   logic [EXP_W-1:0]  w_exp;
   logic              w_fmt_err;
   logic [15:0]       w_res_sext;

   // The last byte is taken straight from the bus so the word latches in CAPTURE.
   daa_byte_unpack u_unpack (
      .i_byte0   (r_slot0),
      .i_byte1   (r_slot1),
      .i_byte2   (r_slot2),
      .i_byte3   (bus.byte_i),
      .o_res     (w_res),
      .o_eres    (w_eres),
      .o_exp     (w_exp),
      .o_fmt_err (w_fmt_err)
   );

   generate
      if (SIGN_EXT) begin : g_sext
         assign w_res_sext = {{(16-RES_W){w_res[RES_W-1]}}, w_res};
      end else begin : g_zext
         assign w_res_sext = {{(16-RES_W){1'b0}}, w_res};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_idx      <= 2'd0;
         r_sel      <= SEL_RES_LO;
         r_hold     <= 1'b0;
         r_slot0    <= 8'd0;
         r_slot1    <= 8'd0;
         r_slot2    <= 8'd0;
         r_res      <= '0;
         r_res_sext <= '0;
         r_eres     <= '0;
         r_exp      <= '0;
         r_fmt_err  <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_idx   <= 2'd0;
                  r_sel   <= SEL_RES_LO;
                  r_hold  <= 1'b1;
                  r_cnt   <= c_CNT_RELOAD;
                  r_state <= ST_SETTLE_W;
               end
            end
            ST_SETTLE_W: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (r_idx != SEL_RES_HI) begin
                  case (r_idx)
                     SEL_RES_LO:   r_slot0 <= bus.byte_i;
                     SEL_ERES_EXP: r_slot1 <= bus.byte_i;
                     default:      r_slot2 <= bus.byte_i;
                  endcase
                  r_idx   <= r_idx + 2'd1;
                  r_sel   <= r_idx + 2'd1;
                  r_cnt   <= c_CNT_RELOAD;
                  r_state <= ST_SETTLE_W;
               end else begin
                  r_res      <= w_res;
                  r_res_sext <= w_res_sext;
                  r_eres     <= w_eres;
                  r_exp      <= w_exp;
                  r_fmt_err  <= w_fmt_err;
                  r_valid    <= 1'b1;
                  r_hold     <= 1'b0;
                  r_state    <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (bus.ready_i) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o         = (r_state != ST_IDLE);
   assign bus.sel_o      = r_sel;
   assign bus.hold_o     = r_hold;
   assign bus.res_o      = r_res;
   assign bus.res_sext_o = r_res_sext;
   assign bus.eres_o     = r_eres;
   assign bus.exp_o      = r_exp;
   assign bus.fmt_err_o  = r_fmt_err;
   assign bus.valid_o    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_daa_result_reader.sv
// ============================================================================
// Module  : tb_daa_result_reader
// Brief   : Scoreboard bench for daa_result_reader (SETTLE=1 sign-ext, SETTLE=3 zero-ext).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_daa_result_reader;
   import daa_pkg::*;

   typedef struct packed {
      logic [9:0]  res;
      logic [15:0] sext;
      logic [17:0] eres;
      logic [2:0]  ex;
      logic        fmt;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic rdy_a = 1'b1;
   logic rdy_b = 1'b1;
   logic busy_a;
   logic busy_b;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [7:0] bytes_a [4];
   logic [7:0] bytes_b [4];
   logic [7:0] byte_b_q = 8'hEE;
   logic [1:0] last_sel_b = 2'd0;
   int         age_b = 7;

   word_t q_a [$];
   word_t q_b [$];
   word_t wa;
   word_t wb;
   bit    seen_a = 1'b0;
   bit    seen_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   daa_result_reader_if ia ();
   daa_result_reader_if ib ();

   daa_result_reader #(.SETTLE(1), .SIGN_EXT(1'b1)) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_a),
      .busy_o  (busy_a),
      .bus     (ia.master)
   );

   daa_result_reader #(.SETTLE(3), .SIGN_EXT(1'b0)) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_b),
      .busy_o  (busy_b),
      .bus     (ib.master)
   );

   assign ia.byte_i  = bytes_a[ia.sel_o];
   assign ia.ready_i = rdy_a;
   assign ib.byte_i  = byte_b_q;
   assign ib.ready_i = rdy_b;

   // Slow bus: a new byte appears two cycles after the select changes, junk before that.
   always @(negedge clk) begin
      if (ib.sel_o != last_sel_b) begin
         last_sel_b = ib.sel_o;
         age_b = 0;
      end else if (age_b < 7) begin
         age_b++;
      end
      byte_b_q = (age_b >= 2) ? bytes_b[last_sel_b] : 8'hEE;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (ia.valid_o && !seen_a) begin
         seen_a = 1'b1;
         if (q_a.size() == 0) begin
            chk("a_unexpected_word", 32'(ia.res_o), 32'hFFFF_FFFF);
         end else begin
            wa = q_a.pop_front();
            chk("a_res",  32'(ia.res_o),      32'(wa.res));
            chk("a_sext", 32'(ia.res_sext_o), 32'(wa.sext));
            chk("a_eres", 32'(ia.eres_o),     32'(wa.eres));
            chk("a_exp",  32'(ia.exp_o),      32'(wa.ex));
            chk("a_fmt",  32'(ia.fmt_err_o),  32'(wa.fmt));
         end
      end
      if (!ia.valid_o) seen_a = 1'b0;
   end

   always @(negedge clk) begin
      if (ib.valid_o && !seen_b) begin
         seen_b = 1'b1;
         if (q_b.size() == 0) begin
            chk("b_unexpected_word", 32'(ib.res_o), 32'hFFFF_FFFF);
         end else begin
            wb = q_b.pop_front();
            chk("b_res",  32'(ib.res_o),      32'(wb.res));
            chk("b_sext", 32'(ib.res_sext_o), 32'(wb.sext));
            chk("b_eres", 32'(ib.eres_o),     32'(wb.eres));
            chk("b_exp",  32'(ib.exp_o),      32'(wb.ex));
            chk("b_fmt",  32'(ib.fmt_err_o),  32'(wb.fmt));
         end
      end
      if (!ib.valid_o) seen_b = 1'b0;
   end

   task automatic set_a(input logic [7:0] b0, b1, b2, b3);
      bytes_a[0] = b0; bytes_a[1] = b1; bytes_a[2] = b2; bytes_a[3] = b3;
   endtask

   // Pulse start on DUT A and return at the negedge where valid_o is first seen.
   task automatic read_a(input word_t w, input string tag);
      int c0;
      bit got;
      q_a.push_back(w);
      @(posedge clk); #1;
      start_a = 1'b1;
      c0 = cyc;
      chk({tag, "_hold_pre"}, 32'(ia.hold_o), 32'd0);
      @(posedge clk); #1;
      start_a = 1'b0;
      chk({tag, "_hold_on"}, 32'(ia.hold_o), 32'd1);
      chk({tag, "_busy_on"}, 32'(busy_a), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ia.valid_o) got = 1'b1;
      end
      if (!got) begin
         chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_latency"}, 32'(cyc - c0), 32'd9);
         chk({tag, "_hold_off"}, 32'(ia.hold_o), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int unstable;
      int busy_seen;
      int nvalid;
      int idle_cnt;
      bit prev_v;
      bit got;
      logic [1:0] last_sel;
      logic [1:0] sel_seen [$];
      logic [9:0] snap_res;
      logic [17:0] snap_eres;
      logic [2:0] snap_exp;

      set_a(8'h00, 8'h00, 8'h00, 8'h00);
      bytes_b[0] = 8'h00; bytes_b[1] = 8'h00; bytes_b[2] = 8'h00; bytes_b[3] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel",   32'(ia.sel_o),   32'd0);
      chk("rst_valid", 32'(ia.valid_o), 32'd0);
      chk("rst_hold",  32'(ia.hold_o),  32'd0);
      chk("rst_busy",  32'(busy_a),     32'd0);
      chk("rst_res",   32'(ia.res_o),   32'd0);
      chk("rst_eres",  32'(ia.eres_o),  32'd0);
      rst_n = 1'b1;

      // T1: res=0x35A, eres={0x0E,0xC7,0x16}=0x1D8F6, exp=3, sign-extended 0xFF5A.
      set_a(8'h5A, 8'hB3, 8'hC7, 8'h6E);
      read_a('{res: 10'h35A, sext: 16'hFF5A, eres: 18'h1D8F6, ex: 3'd3, fmt: 1'b0}, "t1");

      // T2: slow bus on SETTLE=3, zero extension; res=0x212, eres=0x174A7, exp=5.
      bytes_b[0] = 8'h12; bytes_b[1] = 8'h3D; bytes_b[2] = 8'hA5; bytes_b[3] = 8'h4B;
      q_b.push_back('{res: 10'h212, sext: 16'h0212, eres: 18'h174A7, ex: 3'd5, fmt: 1'b0});
      @(posedge clk); #1;
      start_b = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start_b = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ib.valid_o) got = 1'b1;
      end
      if (!got) chk("t2_valid_timeout", 32'd0, 32'd1);
      else      chk("t2_latency", 32'(cyc - c0), 32'd17);

      // T3: consumer stalls 20 cycles; start pulses during PRESENT must be dropped.
      rdy_a = 1'b0;
      set_a(8'h81, 8'h0A, 8'hFF, 8'h1F);
      read_a('{res: 10'h081, sext: 16'h0081, eres: 18'h3FFE1, ex: 3'd2, fmt: 1'b0}, "t3");
      snap_res = ia.res_o;
      snap_eres = ia.eres_o;
      snap_exp = ia.exp_o;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         start_a = (i == 5 || i == 12);
         @(negedge clk);
         if (!ia.valid_o || ia.res_o != snap_res || ia.eres_o != snap_eres ||
             ia.exp_o != snap_exp || !busy_a)
            unstable++;
      end
      start_a = 1'b0;
      chk("t3_stable", 32'(unstable), 32'd0);
      rdy_a = 1'b1;
      @(negedge clk);
      chk("t3_valid_drop", 32'(ia.valid_o), 32'd0);
      chk("t3_res_kept",   32'(ia.res_o),   32'h081);
      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy_a || ia.valid_o) busy_seen++;
      end
      chk("t3_no_queued_start", 32'(busy_seen), 32'd0);

      // T4: reset mid-read clears everything; fresh read sees only new bytes.
      set_a(8'hDE, 8'hAD, 8'hBE, 8'h6F);
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("t4_mid_hold", 32'(ia.hold_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_sel",   32'(ia.sel_o),      32'd0);
      chk("t4_rst_hold",  32'(ia.hold_o),     32'd0);
      chk("t4_rst_busy",  32'(busy_a),        32'd0);
      chk("t4_rst_valid", 32'(ia.valid_o),    32'd0);
      chk("t4_rst_res",   32'(ia.res_o),      32'd0);
      chk("t4_rst_sext",  32'(ia.res_sext_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_a(8'h33, 8'h44, 8'h55, 8'h66);
      read_a('{res: 10'h333, sext: 16'hFF33, eres: 18'h0CAA8, ex: 3'd4, fmt: 1'b0}, "t4");

      // T5: bit 7 of byte 3 set -> format error flagged, word still delivered.
      set_a(8'h00, 8'h00, 8'h00, 8'h80);
      read_a('{res: 10'h000, sext: 16'h0000, eres: 18'h00000, ex: 3'd0, fmt: 1'b1}, "t5");

      // T6: start held high, ready high: three reads, one IDLE cycle between them.
      set_a(8'h5A, 8'hB3, 8'hC7, 8'h6E);
      repeat (3) q_a.push_back('{res: 10'h35A, sext: 16'hFF5A, eres: 18'h1D8F6, ex: 3'd3, fmt: 1'b0});
      @(negedge clk);
      last_sel = ia.sel_o;
      @(posedge clk); #1;
      start_a = 1'b1;
      nvalid = 0;
      idle_cnt = 0;
      prev_v = 1'b0;
      for (int i = 0; i < 60 && nvalid < 3; i++) begin
         @(negedge clk);
         if (ia.sel_o != last_sel) begin
            last_sel = ia.sel_o;
            sel_seen.push_back(last_sel);
         end
         if (nvalid > 0 && !busy_a) idle_cnt++;
         if (ia.valid_o && !prev_v) nvalid++;
         prev_v = ia.valid_o;
      end
      start_a = 1'b0;
      chk("t6_reads", 32'(nvalid), 32'd3);
      chk("t6_idle_gaps", 32'(idle_cnt), 32'd2);
      chk("t6_sel_count", 32'(sel_seen.size()), 32'd12);
      for (int i = 0; i < sel_seen.size() && i < 12; i++)
         chk($sformatf("t6_sel_%0d", i), 32'(sel_seen[i]), 32'(i % 4));

      repeat (5) @(negedge clk);
      chk("q_a_empty", 32'(q_a.size()), 32'd0);
      chk("q_b_empty", 32'(q_b.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
